// File: rtl/bcd_pkg.sv
// Shared types and elaboration helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    function automatic int cnt_w(input int bin_w);
        return $clog2(bin_w + 1);
    endfunction

    // Smallest digit count whose decimal range covers 2**bin_w - 1.
    function automatic int min_digits(input int bin_w);
        logic [127:0] lim;
        logic [127:0] p;
        int           d;
        lim = 128'd1 << bin_w;
        p   = 128'd1;
        d   = 0;
        for (int i = 0; i < 40; i++) begin
            if (p < lim) begin
                p = p * 128'd10;
                d = d + 1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more before the shift.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);

    always_comb begin
        dout = (din >= 4'd5) ? din + 4'd3 : din;
    end

endmodule

// File: rtl/bcd_seq_converter.sv
// Iterative double-dabble binary-to-BCD converter with valid/ready on both sides
// and a registered leading-zero blank mask for the 7-segment digit encoders.
module bcd_seq_converter
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BIN_W-1:0]              bin_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
    output logic [DIGITS-1:0]             digit_blank,
    output logic                          busy
);

    localparam int CW = cnt_w(BIN_W);
    localparam int SW = BCD_DIGIT_W * DIGITS;
    localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

    if (BIN_W < 1) begin : g_bad_bin_w
        $error("bcd_seq_converter: BIN_W must be >= 1");
    end
    if (DIGITS < min_digits(BIN_W)) begin : g_bad_digits
        $error("bcd_seq_converter: DIGITS too small for BIN_W");
    end

    state_t            state;
    state_t            state_nx;
    logic [BIN_W-1:0]  shreg;
    logic [BIN_W-1:0]  shreg_nx;
    logic [SW-1:0]     scratch;
    logic [SW-1:0]     scratch_adj;
    logic [SW-1:0]     scratch_nx;
    logic [CW-1:0]     cnt;
    logic [DIGITS-1:0] blank_nx;
    logic              accept;
    logic              last_step;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .dout (scratch_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign scratch_nx = {scratch_adj[SW-2:0], shreg[BIN_W-1]};
    assign shreg_nx   = shreg << 1;
    assign last_step  = (cnt == CW'(1));

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state == SHIFT);

    // A digit is blanked only if it and every more significant digit are zero;
    // the units digit always shows so a value of 0 displays a single "0".
    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        blank_nx = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero    = all_zero && (scratch_nx[i*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd0);
            blank_nx[i] = all_zero;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = SHIFT;
            SHIFT:   if (last_step) state_nx = DONE;
            DONE: begin
                if (accept)         state_nx = SHIFT;
                else if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Result registers keep the previous value through a restart until the
    // final shift of the new conversion overwrites them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg       <= '0;
            scratch     <= '0;
            cnt         <= '0;
            bcd_out     <= '0;
            digit_blank <= BLANK_RST;
        end else if (accept) begin
            shreg   <= bin_in;
            scratch <= '0;
            cnt     <= CW'(BIN_W);
        end else if (state == SHIFT) begin
            shreg   <= shreg_nx;
            scratch <= scratch_nx;
            cnt     <= cnt - CW'(1);
            if (last_step) begin
                bcd_out     <= scratch_nx;
                digit_blank <= blank_nx;
            end
        end
    end

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Directed self-checking bench for bcd_seq_converter (8-bit/3-digit and 16-bit/5-digit).
module tb_bcd_seq_converter;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  bin_in;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] bcd_out;
    logic [2:0]  digit_blank;
    logic        busy;

    logic        w_in_valid;
    logic        w_in_ready;
    logic [15:0] w_bin_in;
    logic        w_out_valid;
    logic        w_out_ready;
    logic [19:0] w_bcd_out;
    logic [4:0]  w_digit_blank;
    logic        w_busy;

    int n_cmp  = 0;
    int n_fail = 0;

    bcd_seq_converter #(.BIN_W(8), .DIGITS(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .bin_in      (bin_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .bcd_out     (bcd_out),
        .digit_blank (digit_blank),
        .busy        (busy)
    );

    bcd_seq_converter #(.BIN_W(16), .DIGITS(5)) dut_wide (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (w_in_valid),
        .in_ready    (w_in_ready),
        .bin_in      (w_bin_in),
        .out_valid   (w_out_valid),
        .out_ready   (w_out_ready),
        .bcd_out     (w_bcd_out),
        .digit_blank (w_digit_blank),
        .busy        (w_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; bin_in = '0; out_ready = 1'b0;
        w_in_valid = 1'b0; w_bin_in = '0; w_out_ready = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (bcd_out !== 12'h000) begin n_fail++; $display("[TB] FAIL reset_bcd got=%h exp=000", bcd_out); end
        n_cmp++; if (digit_blank !== 3'b110) begin n_fail++; $display("[TB] FAIL reset_blank got=%b exp=110", digit_blank); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (w_digit_blank !== 5'b11110) begin n_fail++; $display("[TB] FAIL reset_wide_blank got=%b exp=11110", w_digit_blank); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_basic();
        logic [7:0]  vals [4] = '{8'd255, 8'd0, 8'd7, 8'd40};
        logic [11:0] ebcd [4] = '{12'h255, 12'h000, 12'h007, 12'h040};
        logic [2:0]  ebl  [4] = '{3'b000, 3'b110, 3'b110, 3'b100};
        int n;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; bin_in = vals[k];
            @(posedge clk); #1;
            in_valid = 1'b0;
            n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_busy v=%0d got=%b exp=1", vals[k], busy); end
            n = 0;
            while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
            n_cmp++; if (n !== 8) begin n_fail++; $display("[TB] FAIL basic_latency v=%0d got=%0d exp=8", vals[k], n); end
            n_cmp++; if (bcd_out !== ebcd[k]) begin n_fail++; $display("[TB] FAIL basic_bcd v=%0d got=%h exp=%h", vals[k], bcd_out, ebcd[k]); end
            n_cmp++; if (digit_blank !== ebl[k]) begin n_fail++; $display("[TB] FAIL basic_blank v=%0d got=%b exp=%b", vals[k], digit_blank, ebl[k]); end
            @(posedge clk); #1;
            n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_to_idle v=%0d got ov=%b ir=%b exp ov=0 ir=1", vals[k], out_valid, in_ready); end
        end
    endtask

    task automatic test_backpressure();
        int n;
        out_ready = 1'b0;
        in_valid = 1'b1; bin_in = 8'd128;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        n_cmp++; if (n !== 8) begin n_fail++; $display("[TB] FAIL bp_latency got=%0d exp=8", n); end
        in_valid = 1'b1; bin_in = 8'd99;
        for (int c = 0; c < 5; c++) begin
            n_cmp++; if (out_valid !== 1'b1 || bcd_out !== 12'h128 || digit_blank !== 3'b000) begin
                n_fail++; $display("[TB] FAIL bp_hold c=%0d got ov=%b bcd=%h bl=%b exp ov=1 bcd=128 bl=000", c, out_valid, bcd_out, digit_blank);
            end
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_in_ready c=%0d got=%b exp=0", c, in_ready); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_release_ready got=%b exp=1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b1 || bcd_out !== 12'h128) begin
            n_fail++; $display("[TB] FAIL bp_restart got ov=%b busy=%b bcd=%h exp ov=0 busy=1 bcd=128", out_valid, busy, bcd_out);
        end
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        n_cmp++; if (n !== 8) begin n_fail++; $display("[TB] FAIL bp_latency2 got=%0d exp=8", n); end
        n_cmp++; if (bcd_out !== 12'h099) begin n_fail++; $display("[TB] FAIL bp_bcd2 got=%h exp=099", bcd_out); end
        n_cmp++; if (digit_blank !== 3'b100) begin n_fail++; $display("[TB] FAIL bp_blank2 got=%b exp=100", digit_blank); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int n;
        int seen;
        out_ready = 1'b1;
        in_valid = 1'b1; bin_in = 8'd200;
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_flags got ov=%b busy=%b exp 0 0", out_valid, busy); end
        n_cmp++; if (bcd_out !== 12'h000) begin n_fail++; $display("[TB] FAIL midrst_bcd got=%h exp=000", bcd_out); end
        n_cmp++; if (digit_blank !== 3'b110) begin n_fail++; $display("[TB] FAIL midrst_blank got=%b exp=110", digit_blank); end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_fail++; $display("[TB] FAIL midrst_no_valid got=%0d exp=0", seen); end
        in_valid = 1'b1; bin_in = 8'd57;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        n_cmp++; if (n !== 8) begin n_fail++; $display("[TB] FAIL midrst_latency got=%0d exp=8", n); end
        n_cmp++; if (bcd_out !== 12'h057) begin n_fail++; $display("[TB] FAIL midrst_bcd57 got=%h exp=057", bcd_out); end
        n_cmp++; if (digit_blank !== 3'b100) begin n_fail++; $display("[TB] FAIL midrst_blank57 got=%b exp=100", digit_blank); end
        @(posedge clk); #1;
    endtask

    task automatic test_stream();
        int sent;
        int got;
        int cyc;
        int last_cyc;
        logic acc;
        logic [11:0] exp_bcd;
        logic [2:0]  exp_bl;
        logic [3:0]  h, t, u;
        sent = 0; got = 0; cyc = 0; last_cyc = 0;
        out_ready = 1'b1;
        in_valid = 1'b1; bin_in = 8'd0;
        for (int guard = 0; guard < 256 * 9 + 60 && got < 256; guard++) begin
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                sent++;
                bin_in = sent[7:0];
                if (sent == 256) in_valid = 1'b0;
            end
            if (out_valid) begin
                h = 4'(got / 100);
                t = 4'((got / 10) % 10);
                u = 4'(got % 10);
                exp_bcd = {h, t, u};
                exp_bl  = {h == 4'd0, (h == 4'd0) && (t == 4'd0), 1'b0};
                n_cmp++; if (bcd_out !== exp_bcd || digit_blank !== exp_bl) begin
                    n_fail++; $display("[TB] FAIL stream_value v=%0d got bcd=%h bl=%b exp bcd=%h bl=%b", got, bcd_out, digit_blank, exp_bcd, exp_bl);
                end
                if (got > 0) begin
                    n_cmp++; if (cyc - last_cyc !== 9) begin n_fail++; $display("[TB] FAIL stream_period v=%0d got=%0d exp=9", got, cyc - last_cyc); end
                end
                last_cyc = cyc;
                got++;
            end
        end
        in_valid = 1'b0;
        n_cmp++; if (got !== 256) begin n_fail++; $display("[TB] FAIL stream_count got=%0d exp=256", got); end
        @(posedge clk); #1;
    endtask

    task automatic test_wide();
        logic [15:0] vals [3] = '{16'd65535, 16'd1000, 16'd0};
        logic [19:0] ebcd [3] = '{20'h65535, 20'h01000, 20'h00000};
        logic [4:0]  ebl  [3] = '{5'b00000, 5'b10000, 5'b11110};
        int n;
        w_out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            w_in_valid = 1'b1; w_bin_in = vals[k];
            @(posedge clk); #1;
            w_in_valid = 1'b0;
            n = 0;
            while (!w_out_valid && n < 40) begin @(posedge clk); #1; n++; end
            n_cmp++; if (n !== 16) begin n_fail++; $display("[TB] FAIL wide_latency v=%0d got=%0d exp=16", vals[k], n); end
            n_cmp++; if (w_bcd_out !== ebcd[k]) begin n_fail++; $display("[TB] FAIL wide_bcd v=%0d got=%h exp=%h", vals[k], w_bcd_out, ebcd[k]); end
            n_cmp++; if (w_digit_blank !== ebl[k]) begin n_fail++; $display("[TB] FAIL wide_blank v=%0d got=%b exp=%b", vals[k], w_digit_blank, ebl[k]); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_mid();
        test_stream();
        test_wide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
